// File: rtl/rect_plot_arbiter_if.sv
// Client/adapter bundle for rect_plot_arbiter: per-client rectangle requests in,
// grant/done and the single pixel-write port out.
interface rect_plot_arbiter_if #(
  parameter int NREQ = 3
);
  // Handshake: req[i] is a level held by client i until it sees done[i] pulse;
  // grant[i] stays high for the whole service and done[i] is a 1-cycle pulse.
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] rect_x;
  logic [7*NREQ-1:0] rect_y;
  logic [4*NREQ-1:0] rect_w;
  logic [4*NREQ-1:0] rect_h;
  logic [3*NREQ-1:0] rect_col;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic [7:0]        vga_x;
  logic [6:0]        vga_y;
  logic [2:0]        vga_colour;
  logic              plot;
  logic [1:0]        state_dbg;

  modport master (
    output req, rect_x, rect_y, rect_w, rect_h, rect_col,
    input  grant, done, busy, vga_x, vga_y, vga_colour, plot, state_dbg
  );

  modport slave (
    input  req, rect_x, rect_y, rect_w, rect_h, rect_col,
    output grant, done, busy, vga_x, vga_y, vga_colour, plot, state_dbg
  );
endinterface

// File: rtl/rect_plot_arbiter.sv
// Round-robin arbiter sharing one VGA pixel-write port between NREQ rectangle
// fill clients; the granted rectangle is scanned row-major, one pixel per clock.
module rect_plot_arbiter #(
  parameter int NREQ    = 3,
  parameter int XSCREEN = 160,
  parameter int YSCREEN = 120
) (
  input logic            Clock,
  input logic            Resetn,
  rect_plot_arbiter_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   sel_q, sel_d;
  logic [7:0]      x_q, x_d;
  logic [6:0]      y_q, y_d;
  logic [3:0]      w_q, w_d;
  logic [3:0]      h_q, h_d;
  logic [2:0]      col_q, col_d;
  logic [3:0]      xc_q, xc_d;
  logic [3:0]      yc_q, yc_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            busy_q, busy_d;
  logic [7:0]      vga_x_q, vga_x_d;
  logic [6:0]      vga_y_q, vga_y_d;
  logic [2:0]      vga_colour_q, vga_colour_d;
  logic            plot_q, plot_d;

  logic            pick_found;
  logic [PW-1:0]   pick_idx;
  logic [8:0]      sum_x;
  logic [7:0]      sum_y;

  // First requesting client strictly after the last served one, wrapping.
  always_comb begin
    int idx;
    idx        = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!pick_found && bus.req[idx]) begin
        pick_found = 1'b1;
        pick_idx   = PW'(idx);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    sel_d        = sel_q;
    x_d          = x_q;
    y_d          = y_q;
    w_d          = w_q;
    h_d          = h_q;
    col_d        = col_q;
    xc_d         = xc_q;
    yc_d         = yc_q;
    grant_d      = '0;
    done_d       = '0;
    busy_d       = 1'b0;
    vga_x_d      = '0;
    vga_y_d      = '0;
    vga_colour_d = '0;
    plot_d       = 1'b0;
    sum_x        = '0;
    sum_y        = '0;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          sel_d = pick_idx;
          ptr_d = pick_idx;
          x_d   = bus.rect_x[pick_idx*8 +: 8];
          y_d   = bus.rect_y[pick_idx*7 +: 7];
          w_d   = bus.rect_w[pick_idx*4 +: 4];
          h_d   = bus.rect_h[pick_idx*4 +: 4];
          col_d = bus.rect_col[pick_idx*3 +: 3];
          xc_d  = '0;
          yc_d  = '0;
          if (w_d == 4'd0 || h_d == 4'd0) state_d = DONE;
          else                            state_d = DRAW;
        end
      end
      DRAW: begin
        if (xc_q == w_q - 4'd1 && yc_q == h_q - 4'd1) begin
          state_d = DONE;
        end else if (xc_q == w_q - 4'd1) begin
          xc_d = '0;
          yc_d = yc_q + 4'd1;
        end else begin
          xc_d = xc_q + 4'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Output registers are loaded with what the next state presents, so the
    // first pixel appears on the cycle right after the request is sampled.
    if (state_d == DRAW) begin
      sum_x          = {1'b0, x_d} + {5'b0, xc_d};
      sum_y          = {1'b0, y_d} + {4'b0, yc_d};
      grant_d[sel_d] = 1'b1;
      busy_d         = 1'b1;
      vga_x_d        = sum_x[7:0];
      vga_y_d        = sum_y[6:0];
      vga_colour_d   = col_d;
      plot_d         = (sum_x < 9'(XSCREEN)) && (sum_y < 8'(YSCREEN));
    end else if (state_d == DONE) begin
      grant_d[sel_d] = 1'b1;
      done_d[sel_d]  = 1'b1;
      busy_d         = 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q      <= IDLE;
      ptr_q        <= PW'(NREQ - 1);
      sel_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      w_q          <= '0;
      h_q          <= '0;
      col_q        <= '0;
      xc_q         <= '0;
      yc_q         <= '0;
      grant_q      <= '0;
      done_q       <= '0;
      busy_q       <= 1'b0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      plot_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      sel_q        <= sel_d;
      x_q          <= x_d;
      y_q          <= y_d;
      w_q          <= w_d;
      h_q          <= h_d;
      col_q        <= col_d;
      xc_q         <= xc_d;
      yc_q         <= yc_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      plot_q       <= plot_d;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.done       = done_q;
  assign bus.busy       = busy_q;
  assign bus.vga_x      = vga_x_q;
  assign bus.vga_y      = vga_y_q;
  assign bus.vga_colour = vga_colour_q;
  assign bus.plot       = plot_q;
  assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_rect_plot_arbiter.sv
// Bench for rect_plot_arbiter: a rectangle/round-robin reference model fills
// expected queues, a negedge monitor pops and compares whatever the DUT emits.
module tb_rect_plot_arbiter;
  localparam int NREQ = 3;

  logic clk;
  logic Resetn;

  rect_plot_arbiter_if #(.NREQ(NREQ)) bus();

  rect_plot_arbiter #(.NREQ(NREQ), .XSCREEN(160), .YSCREEN(120)) dut (
    .Clock  (clk),
    .Resetn (Resetn),
    .bus    (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  logic [20:0] exp_q[$];       // {client[2:0], x[7:0], y[6:0], col[2:0]}
  logic [2:0]  exp_done_q[$];  // client index per completed service
  int          exp_grant_cycles;

  int rx[NREQ], ry[NREQ], rw[NREQ], rh[NREQ], rc[NREQ];
  int mptr;

  // request gating: driver owns req_set/hold_mode/hold_end/batch_tog,
  // monitor owns served/done_total/grant_cycles/pix_seen
  logic [NREQ-1:0] req_set = '0;
  logic [NREQ-1:0] served  = '0;
  bit              hold_mode = 1'b0;
  int              hold_end  = 0;
  int              done_total = 0;
  int              grant_cycles = 0;
  int              pix_seen = 0;
  bit              batch_tog = 1'b0;
  bit              last_tog  = 1'b0;

  assign bus.req = hold_mode ? ((done_total >= hold_end) ? '0 : req_set)
                             : (req_set & ~served);

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void model_service(input int i);
    for (int r = 0; r < rh[i]; r++)
      for (int c = 0; c < rw[i]; c++) begin
        int sx, sy;
        sx = rx[i] + c;
        sy = ry[i] + r;
        if (sx < 160 && sy < 120)
          exp_q.push_back({3'(i), 8'(sx), 7'(sy), 3'(rc[i])});
      end
    exp_done_q.push_back(3'(i));
    exp_grant_cycles += rw[i] * rh[i] + 1;
  endfunction

  function automatic int model_next(input logic [NREQ-1:0] m);
    for (int k = 1; k <= NREQ; k++)
      if (m[(mptr + k) % NREQ]) return (mptr + k) % NREQ;
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_rect(input int i, input int x, input int y,
                          input int w, input int h, input int col);
    rx[i] = x; ry[i] = y; rw[i] = w; rh[i] = h; rc[i] = col;
    bus.rect_x[i*8 +: 8]   = 8'(x);
    bus.rect_y[i*7 +: 7]   = 7'(y);
    bus.rect_w[i*4 +: 4]   = 4'(w);
    bus.rect_h[i*4 +: 4]   = 4'(h);
    bus.rect_col[i*3 +: 3] = 3'(col);
  endtask

  task automatic do_reset();
    Resetn = 1'b0;
    repeat (2) @(negedge clk);
    Resetn = 1'b1;
    mptr = NREQ - 1;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (bus.req == '0 && !bus.busy) begin ok = 1'b1; break; end
    end
    chk({name, "_timeout"}, int'(ok), 1);
    req_set   = '0;
    hold_mode = 1'b0;
  endtask

  task automatic end_checks(input string name, input int gc_start);
    chk({name, "_pix_left"}, exp_q.size(), 0);
    chk({name, "_done_left"}, exp_done_q.size(), 0);
    chk({name, "_grant_cycles"}, grant_cycles - gc_start, exp_grant_cycles);
    exp_q.delete();
    exp_done_q.delete();
  endtask

  // hold_n == 0: each client drops req on its done; otherwise all held for hold_n services
  task automatic run_batch(input string name, input logic [NREQ-1:0] mask,
                           input int hold_n, input bit chk_first_pixel);
    logic [NREQ-1:0] m;
    int gc_start, nxt;
    batch_tog = ~batch_tog;
    @(negedge clk);
    exp_grant_cycles = 0;
    m = mask;
    if (hold_n == 0) begin
      while (m != '0) begin
        nxt = model_next(m);
        model_service(nxt);
        mptr = nxt;
        m[nxt] = 1'b0;
      end
    end else begin
      for (int s = 0; s < hold_n; s++) begin
        nxt = model_next(m);
        model_service(nxt);
        mptr = nxt;
      end
      hold_end  = done_total + hold_n;
      hold_mode = 1'b1;
    end
    gc_start = grant_cycles;
    req_set  = mask;
    @(posedge clk);
    #1;
    chk({name, "_busy_after_sample"}, int'(bus.busy), 1);
    if (chk_first_pixel) chk({name, "_first_pixel_plot"}, int'(bus.plot), 1);
    wait_idle(name);
    end_checks(name, gc_start);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [20:0] e;
    logic [2:0]  di;
    if (batch_tog != last_tog) begin
      served   = '0;
      last_tog = batch_tog;
    end
    if (Resetn) begin
      if (|bus.grant) grant_cycles++;
      if (bus.plot) begin
        pix_seen++;
        if (exp_q.size() == 0) begin
          chk("unexpected_plot", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("pix_x", int'(bus.vga_x), int'(e[17:10]));
          chk("pix_y", int'(bus.vga_y), int'(e[9:3]));
          chk("pix_col", int'(bus.vga_colour), int'(e[2:0]));
          chk("pix_grant", int'(bus.grant), 1 << e[20:18]);
        end
      end
      if (bus.done != '0) begin
        if (exp_done_q.size() == 0) begin
          chk("unexpected_done", int'(bus.done), 0);
        end else begin
          di = exp_done_q.pop_front();
          chk("done_onehot", int'(bus.done), 1 << di);
          chk("done_grant", int'(bus.grant), 1 << di);
          chk("done_no_plot", int'(bus.plot), 0);
        end
        served = served | bus.done;
        done_total++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int gc_start, start_pix, ok;
    Resetn = 1'b0;
    bus.rect_x = '0; bus.rect_y = '0; bus.rect_w = '0;
    bus.rect_h = '0; bus.rect_col = '0;
    for (int i = 0; i < NREQ; i++) set_rect(i, 0, 0, 0, 0, 0);
    mptr = NREQ - 1;
    #12;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_plot", int'(bus.plot), 0);
    chk("rst_grant", int'(bus.grant), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_xy", int'({bus.vga_x, bus.vga_y, bus.vga_colour}), 0);
    chk("rst_state", int'(bus.state_dbg), 0);
    do_reset();

    // 2x2 fill at (10,20)
    set_rect(0, 10, 20, 2, 2, 3'b100);
    run_batch("basic2x2", 3'b001, 0, 1'b1);

    // simultaneous 1x1 requests, then all three held continuously
    do_reset();
    set_rect(0, 1, 1, 1, 1, 1);
    set_rect(1, 2, 2, 1, 1, 2);
    set_rect(2, 3, 3, 1, 1, 3);
    run_batch("simul01", 3'b011, 0, 1'b1);
    do_reset();
    run_batch("hold_all", 3'b111, 4, 1'b1);

    // clipping at the bottom-right corner
    set_rect(2, 158, 118, 4, 4, 6);
    run_batch("clip", 3'b100, 0, 1'b1);

    // zero-width and zero-height rectangles
    set_rect(1, 5, 5, 0, 5, 7);
    run_batch("zero_w", 3'b010, 0, 1'b0);
    set_rect(0, 5, 5, 3, 0, 7);
    run_batch("zero_h", 3'b001, 0, 1'b0);

    // reset in the middle of a 10x10 service, request left asserted
    set_rect(0, 30, 40, 10, 10, 5);
    batch_tog = ~batch_tog;
    @(negedge clk);
    exp_grant_cycles = 0;
    model_service(0);
    start_pix = pix_seen;
    req_set = 3'b001;
    ok = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (pix_seen >= start_pix + 5) begin ok = 1; break; end
    end
    chk("midreset_reach_pixel5", ok, 1);
    #2 Resetn = 1'b0;
    #1;
    chk("midreset_busy", int'(bus.busy), 0);
    chk("midreset_plot", int'(bus.plot), 0);
    chk("midreset_grant", int'(bus.grant), 0);
    chk("midreset_xyc", int'({bus.vga_x, bus.vga_y, bus.vga_colour}), 0);
    exp_q.delete();
    exp_done_q.delete();
    exp_grant_cycles = 0;
    mptr = NREQ - 1;
    model_service(0);
    mptr = 0;
    repeat (2) @(negedge clk);
    gc_start = grant_cycles;
    Resetn = 1'b1;
    wait_idle("midreset");
    end_checks("midreset", gc_start);

    // rectangle inputs changed during service are ignored
    set_rect(0, 40, 10, 3, 3, 2);
    fork
      run_batch("latch_x40", 3'b001, 0, 1'b1);
      begin
        repeat (3) @(negedge clk);
        bus.rect_x[7:0] = 8'd90;
      end
    join
    set_rect(0, 90, 10, 2, 1, 2);
    run_batch("latch_x90", 3'b001, 0, 1'b1);

    // randomized batches
    for (int b = 0; b < 24; b++) begin
      for (int i = 0; i < NREQ; i++) begin
        int xx, yy;
        xx = ($urandom_range(0, 3) == 0) ? $urandom_range(145, 255) : $urandom_range(0, 159);
        yy = ($urandom_range(0, 3) == 0) ? $urandom_range(105, 127) : $urandom_range(0, 119);
        set_rect(i, xx, yy, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7));
      end
      if (b % 6 == 5)
        run_batch("rand_hold", 3'($urandom_range(1, 7)), $urandom_range(2, 5), 1'b0);
      else
        run_batch("rand", 3'($urandom_range(1, 7)), 0, 1'b0);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
